// File: rtl/sad_block_accumulator_pkg.sv
// Shared defaults and result-width derivation for the SAD accumulator family.
// Sized so that a full block of maximum differences cannot overflow.
package sad_block_accumulator_pkg;

  localparam int DEFAULT_DWIDTH    = 21;
  localparam int DEFAULT_BLOCK_LEN = 64;

  // Width that holds BLOCK_LEN * (2**DWIDTH - 1) without wrapping.
  function automatic int sad_width(input int dwidth, input int block_len);
    return dwidth + $clog2(block_len);
  endfunction

endpackage

// File: rtl/sad_block_accumulator_absdiff_reg_stage.sv
// Registered |A-B| stage with enable, synchronous flush and a valid bit.
// Kept standalone so multi-lane SAD arrays can instantiate one per lane.
module absdiff_reg_stage
  import sad_block_accumulator_pkg::*;
#(
  parameter int DWIDTH = DEFAULT_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  output logic [DWIDTH-1:0] d_q,
  output logic              d_v
);

  logic [DWIDTH-1:0] diff;

  // Subtracting the smaller from the larger keeps the result exact in DWIDTH bits.
  assign diff = (in_a > in_b) ? (in_a - in_b) : (in_b - in_a);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
      d_v <= 1'b0;
    end else if (flush) begin
      d_v <= 1'b0;
    end else if (en) begin
      d_q <= diff;
      d_v <= in_valid;
    end
  end

endmodule

// File: rtl/sad_block_accumulator.sv
// Streaming SAD engine: one (A,B) pair per cycle, one result per BLOCK_LEN pairs,
// delivered on a valid/ready output with back-pressure into the input side.
module sad_block_accumulator
  import sad_block_accumulator_pkg::*;
#(
  parameter int  DWIDTH    = DEFAULT_DWIDTH,
  parameter int  BLOCK_LEN = DEFAULT_BLOCK_LEN,
  localparam int SWIDTH    = sad_width(DWIDTH, BLOCK_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SWIDTH-1:0] out_sad,
  output logic              busy
);

  localparam int                CWIDTH = $clog2(BLOCK_LEN);
  localparam logic [CWIDTH-1:0] LAST   = CWIDTH'(BLOCK_LEN - 1);

  logic [DWIDTH-1:0] d_q;
  logic              d_v;
  logic [SWIDTH-1:0] acc;
  logic [CWIDTH-1:0] cnt;
  logic [SWIDTH-1:0] sum;
  logic              last;
  logic              stall;
  logic              adv;
  logic              take;
  logic              done;

  assign last  = (cnt == LAST);
  // Only the block-closing pair can be blocked, and only by an unconsumed result.
  assign stall = d_v && last && out_valid && !out_ready;
  assign adv   = !stall && !clr;
  // Combinational from out_ready/clr: the consumer sees a direct timing path here.
  assign in_ready = adv;
  assign take  = d_v && adv;
  assign done  = take && last;
  assign sum   = acc + SWIDTH'(d_q);
  assign busy  = (cnt != '0) || d_v;

  absdiff_reg_stage #(
    .DWIDTH(DWIDTH)
  ) u_absdiff (
    .clk      (clk),
    .rst      (rst),
    .en       (adv),
    .flush    (clr),
    .in_valid (in_valid),
    .in_a     (in_a),
    .in_b     (in_b),
    .d_q      (d_q),
    .d_v      (d_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A completion in the same cycle as a handshake keeps out_valid high with the new sum.
  // A pending result survives clr; only rst drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sad   <= '0;
    end else if (done) begin
      out_valid <= 1'b1;
      out_sad   <= sum;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sad_block_accumulator.sv
// Directed checks on a small instance (DWIDTH=8, BLOCK_LEN=4) and a randomized
// scoreboard run on the full-size instance (DWIDTH=21, BLOCK_LEN=64).
module tb_sad_block_accumulator;

  localparam int SW_S  = 10;
  localparam int DW_L  = 21;
  localparam int BL_L  = 64;
  localparam int SW_L  = 27;
  localparam int NBLK  = 1000;
  localparam int MAXCYC = 90000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic            s_clr = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [7:0]      s_in_a = '0, s_in_b = '0;
  logic            s_in_ready, s_out_valid, s_busy;
  logic [SW_S-1:0] s_out_sad;

  logic            l_clr = 1'b0, l_in_valid = 1'b0, l_out_ready = 1'b0;
  logic [DW_L-1:0] l_in_a = '0, l_in_b = '0;
  logic            l_in_ready, l_out_valid, l_busy;
  logic [SW_L-1:0] l_out_sad;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sad_block_accumulator #(.DWIDTH(8), .BLOCK_LEN(4)) u_small (
    .clk(clk), .rst(rst), .clr(s_clr), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sad(s_out_sad), .busy(s_busy)
  );

  sad_block_accumulator #(.DWIDTH(DW_L), .BLOCK_LEN(BL_L)) u_large (
    .clk(clk), .rst(rst), .clr(l_clr), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_a(l_in_a), .in_b(l_in_b), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_sad(l_out_sad), .busy(l_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]      ta [4];
    logic [7:0]      tb [4];
    int unsigned     exp_q [$];
    int unsigned     m_sum, m_cnt, sent, got, cyc;
    logic            pending;
    logic [63:0]     exp_sad;

    // Reset state, sampled while rst is still asserted.
    #3;
    check("rst_out_valid", s_out_valid, 0);
    check("rst_out_sad",   s_out_sad,   0);
    check("rst_in_ready",  s_in_ready,  1);
    check("rst_busy",      s_busy,      0);
    #10 rst = 1'b0;
    tick();

    // 1: mixed pairs, single block, SAD = 7+7+255+0 = 269, valid 2 cycles after 4th accept.
    ta = '{8'd10, 8'd3, 8'd0,   8'd7};
    tb = '{8'd3,  8'd10, 8'd255, 8'd7};
    s_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      s_in_valid = (k < 4);
      s_in_a = (k < 4) ? ta[k] : 8'd0;
      s_in_b = (k < 4) ? tb[k] : 8'd0;
      @(negedge clk);
      check("t1_in_ready", s_in_ready, 1);
      check("t1_out_valid", s_out_valid, (k == 5));
      if (k == 5) check("t1_out_sad", s_out_sad, 269);
      if (k == 4) check("t1_busy_pipe", s_busy, 1);
      if (k == 6) check("t1_busy_idle", s_busy, 0);
      tick();
    end

    // 2: eight max-difference pairs, results 1020 at cycles 5 and 9, no bubbles.
    for (int k = 0; k < 11; k++) begin
      s_in_valid = (k < 8);
      s_in_a = 8'd255;
      s_in_b = 8'd0;
      @(negedge clk);
      check("t2_in_ready", s_in_ready, 1);
      check("t2_out_valid", s_out_valid, (k == 5 || k == 9));
      if (k == 5 || k == 9) check("t2_out_sad", s_out_sad, 1020);
      tick();
    end

    // 3: back-pressure; block of (9,2)=28 held, second block of (1,0)=4 stalls its last pair.
    for (int k = 0; k < 13; k++) begin
      s_in_valid  = (k < 8);
      s_in_a      = (k < 4) ? 8'd9 : 8'd1;
      s_in_b      = (k < 4) ? 8'd2 : 8'd0;
      s_out_ready = (k >= 10);
      @(negedge clk);
      check("t3_in_ready", s_in_ready, !(k == 8 || k == 9));
      check("t3_out_valid", s_out_valid, (k >= 5 && k <= 11));
      if (k >= 5 && k <= 10) check("t3_out_sad_first", s_out_sad, 28);
      if (k == 11)           check("t3_out_sad_second", s_out_sad, 4);
      tick();
    end

    // 4: partial block flushed by clr; the pair presented with clr is refused.
    for (int k = 0; k < 10; k++) begin
      s_in_valid = (k < 7);
      s_clr      = (k == 2);
      s_in_a     = (k < 2) ? 8'd5 : ((k == 2) ? 8'd100 : 8'd2);
      s_in_b     = (k < 2) ? 8'd1 : 8'd0;
      @(negedge clk);
      check("t4_in_ready", s_in_ready, (k != 2));
      if (k == 3) check("t4_busy_after_clr", s_busy, 0);
      check("t4_out_valid", s_out_valid, (k == 8));
      if (k == 8) check("t4_out_sad", s_out_sad, 8);
      tick();
    end
    s_clr = 1'b0;

    // 5: async reset while a result is pending and a block is partially summed.
    s_out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_in_valid = 1'b1;
      s_in_a = (k < 4) ? 8'd3 : 8'd1;
      s_in_b = 8'd0;
      tick();
    end
    s_in_valid = 1'b0;
    #1;
    check("t5_pre_out_valid", s_out_valid, 1);
    check("t5_pre_out_sad",   s_out_sad,   12);
    check("t5_pre_busy",      s_busy,      1);
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", s_out_valid, 0);
    check("t5_rst_out_sad",   s_out_sad,   0);
    check("t5_rst_busy",      s_busy,      0);
    check("t5_rst_in_ready",  s_in_ready,  1);
    #2 rst = 1'b0;
    tick();
    s_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      s_in_valid = (k < 4);
      s_in_a = 8'd1;
      s_in_b = 8'd0;
      @(negedge clk);
      check("t5_out_valid", s_out_valid, (k == 5));
      if (k == 5) check("t5_out_sad", s_out_sad, 4);
      tick();
    end

    // 6: randomized traffic on the full-size instance against a running-sum scoreboard.
    m_sum = 0; m_cnt = 0; sent = 0; got = 0; cyc = 0; pending = 1'b0;
    while ((sent < NBLK * BL_L || got < NBLK) && cyc < MAXCYC) begin
      if (!pending && sent < NBLK * BL_L && $urandom_range(15) != 0) begin
        l_in_a  = ($urandom_range(7) == 0) ? {DW_L{1'b1}} : DW_L'($urandom);
        l_in_b  = ($urandom_range(7) == 0) ? '0 : DW_L'($urandom);
        if ($urandom_range(15) == 0) l_in_b = l_in_a;
        pending = 1'b1;
      end
      l_in_valid  = pending;
      l_out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (l_in_valid && l_in_ready) begin
        m_sum += (l_in_a > l_in_b) ? (l_in_a - l_in_b) : (l_in_b - l_in_a);
        m_cnt++;
        sent++;
        pending = 1'b0;
        if (m_cnt == BL_L) begin
          exp_q.push_back(m_sum);
          m_sum = 0;
          m_cnt = 0;
        end
      end
      if (l_out_valid && l_out_ready) begin
        exp_sad = (exp_q.size() != 0) ? 64'(exp_q.pop_front()) : 64'bx;
        check("t6_out_sad", l_out_sad, exp_sad);
        got++;
      end
      tick();
      cyc++;
    end
    l_in_valid = 1'b0;
    check("t6_result_count", got, NBLK);
    check("t6_unconsumed", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
